id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register feeding the ALU: latches decoded operands, ALU select and destination info, and drives the ALU's x32bit, y32bit and sel inputs from registers.
- Resolves data hazards with operand forwarding from the ALU result (EX) and the write-back result (WB).
- Inserts a one-cycle bubble on load-use hazards.
- Supports a downstream stall (ex_ready) and a flush from branch resolution.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
SEL_W, 4, ALU select width
NOP_SEL, 4'b0111, ALU select driven during bubbles/reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_ready  out  1  stage accepts the ID instruction this cycle
id_rs_addr  in  REG_AW  source register s
id_rt_addr  in  REG_AW  source register t
id_rd_addr  in  REG_AW  destination register
id_rs_data  in  DATA_W  register-file value of rs
id_rt_data  in  DATA_W  register-file value of rt
id_imm  in  DATA_W  sign-extended immediate
id_use_imm  in  1  1: y operand = id_imm
id_sel  in  SEL_W  ALU operation
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
id_mem_write  in  1  instruction is a store
alu_res32bit  in  DATA_W  ALU result of the instruction currently held in EX
wb_valid  in  1  WB result valid
wb_reg_write  in  1  WB writes a register
wb_rd_addr  in  REG_AW  WB destination
wb_result  in  DATA_W  WB data (ALU or load)
ex_ready  in  1  downstream (EX/MEM) accepts this cycle
flush  in  1  kill the EX contents and the ID input
ex_valid  out  1  EX holds a valid instruction
x32bit  out  DATA_W  ALU operand x
y32bit  out  DATA_W  ALU operand y
sel  out  SEL_W  ALU select
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_rd_addr  out  REG_AW  destination register
ex_reg_write  out  1  write-enable, qualified by ex_valid
ex_mem_read  out  1  load flag
ex_mem_write  out  1  store flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ex_valid=0, sel=NOP_SEL.
  - All data, address and control outputs are 0.
- Register update priority, each rising edge:
  1. flush: ex_valid←0, sel←NOP_SEL, control flags←0. This applies even when ex_ready=0.
  2. ex_ready=0: hold all registers.
  3. load_use: insert a bubble (ex_valid←0, sel←NOP_SEL, flags←0).
  4. id_valid: capture the ID instruction with forwarded operands.
  5. Otherwise: bubble.
- load_use hazard condition: ex_valid & ex_mem_read & ex_rd_addr≠0 & (ex_rd_addr==id_rs_addr | (ex_rd_addr==id_rt_addr & (!id_use_imm | id_mem_write))).
- id_ready is combinational: id_ready = flush | (ex_ready & !load_use).
  - On flush the ID instruction is consumed and discarded.
- Forwarding is evaluated per source (rs, rt) at capture time. Highest priority first:
  - EX forward: ex_valid & ex_reg_write & !ex_mem_read & ex_rd_addr==src & src≠0 → alu_res32bit.
  - WB forward: wb_valid & wb_reg_write & wb_rd_addr==src & src≠0 → wb_result.
  - Otherwise the register-file data.
  - Register 0 always reads the register-file value, never forwarded.
- Operand mapping:
  - x32bit←fwd_rs.
  - y32bit←id_use_imm ? id_imm : fwd_rt.
  - ex_store_data←fwd_rt.
- Latency: exactly 1 cycle from an accepted ID instruction to the EX outputs. A load-use stall adds 1 bubble cycle; the ID instruction is held and re-sampled.
- A held EX instruction keeps its operands frozen and does not re-forward. This is correct because the producer has already left EX.
- sel=NOP_SEL whenever ex_valid=0, so the ALU result is 0 and its zero flag is 1. Downstream must qualify all use of that result with ex_valid.
- Widths are fixed; there is no arithmetic in this block (mux and compare only).

Decomposition:
- Shared package holds:
  - ALU select constants: ADD 0000, SUB 0001, MUL 0010, DIV 0011, AND 0100, OR 0101, NOR 0110, NOP 0111, SLT 1001, XOR 1010.
  - REG_AW and DATA_W.
- One sub-module, fwd_unit (combinational): takes the source address, register-file data, and the EX/WB candidates, and returns the forwarded value. It is instantiated twice (rs, rt).
- Load-use detection and the pipeline register stay in id_ex_stage.

Test Plan:
1. Reset mid-operation: assert rst_n=0 while ex_valid=1 → outputs go 0 immediately, without waiting for a clock edge, and sel=0111.
2. EX forward: the EX instruction is ADD to r3 with alu_res32bit=0x0000_0010. ID issues SUB with rs=r3, id_rs_data=0xDEAD_BEEF. → next cycle x32bit=0x0000_0010, sel=0001.
3. Priority and r0: EX writes r5=0x11 and WB writes r5=0x22, with ID rs=r5 → x32bit=0x11. Repeat with rd=r0 and id_rs_data=0 → x32bit=0.
4. Load-use: EX holds a load to r4 and ID issues AND with rt=r4, id_use_imm=0.
   - Cycle 1: id_ready=0, then a bubble with ex_valid=0, sel=0111.
   - Cycle 2, with WB (r4=0x0F0F_0000): y32bit=0x0F0F_0000 and ex_valid=1.
5. Downstream stall: ex_ready=0 for 3 cycles with ex_valid=1 → all outputs are unchanged and id_ready=0. Releasing ex_ready → the next ID instruction is captured on the following edge.
6. Flush during stall: ex_ready=0, flush=1 → next edge ex_valid=0, sel=0111, ex_reg_write=0; id_ready=1 during flush.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths and ALU select encodings for the ID/EX slice
package id_ex_stage_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int SEL_W  = 4;
  typedef enum logic [SEL_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_NOR = 4'b0110,
    ALU_NOP = 4'b0111,
    ALU_SLT = 4'b1001,
    ALU_XOR = 4'b1010
  } alu_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// id_ex_stage_fwd_unit: picks EX result, WB result or register-file data for one source operand
module id_ex_stage_fwd_unit
  import id_ex_stage_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd
);
  logic nz;
  always_comb begin
    nz  = |src;
    fwd = (nz && ex_en && ex_rd == src) ? ex_data :
          (nz && wb_en && wb_rd == src) ? wb_data : rf_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/WB operand forwarding,
// load-use bubble insertion, downstream stall and branch flush
module id_ex_stage #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int SEL_W  = id_ex_stage_pkg::SEL_W,
  parameter logic [SEL_W-1:0] NOP_SEL = id_ex_stage_pkg::ALU_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [SEL_W-1:0]  id_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [DATA_W-1:0] alu_res32bit,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] x32bit,
  output logic [DATA_W-1:0] y32bit,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  logic              load_use, cap, bub, ex_fwd_en, wb_fwd_en;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  always_comb begin
    load_use  = ex_valid && ex_mem_read && |ex_rd_addr &&
                (ex_rd_addr == id_rs_addr ||
                 (ex_rd_addr == id_rt_addr && (!id_use_imm || id_mem_write)));
    id_ready  = flush || (ex_ready && !load_use);
    cap       = !flush && ex_ready && !load_use && id_valid;
    bub       = flush || (ex_ready && !cap);
    // a load's result is not available from the ALU, so only non-loads forward from EX
    ex_fwd_en = ex_valid && ex_reg_write && !ex_mem_read;
    wb_fwd_en = wb_valid && wb_reg_write;
  end
  id_ex_stage_fwd_unit u_fwd_rs (
    .src(id_rs_addr), .rf_data(id_rs_data),
    .ex_en(ex_fwd_en), .ex_rd(ex_rd_addr), .ex_data(alu_res32bit),
    .wb_en(wb_fwd_en), .wb_rd(wb_rd_addr), .wb_data(wb_result),
    .fwd(fwd_rs)
  );
  id_ex_stage_fwd_unit u_fwd_rt (
    .src(id_rt_addr), .rf_data(id_rt_data),
    .ex_en(ex_fwd_en), .ex_rd(ex_rd_addr), .ex_data(alu_res32bit),
    .wb_en(wb_fwd_en), .wb_rd(wb_rd_addr), .wb_data(wb_result),
    .fwd(fwd_rt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      sel          <= NOP_SEL;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (cap) begin
      ex_valid     <= 1'b1;
      sel          <= id_sel;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
    end else if (bub) begin
      ex_valid     <= 1'b0;
      sel          <= NOP_SEL;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end
  end
  // operands are frozen while held; bubbles leave stale data behind an invalid ex_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x32bit        <= '0;
      y32bit        <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= '0;
    end else if (cap) begin
      x32bit        <= fwd_rs;
      y32bit        <= id_use_imm ? id_imm : fwd_rt;
      ex_store_data <= fwd_rt;
      ex_rd_addr    <= id_rd_addr;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        id_valid, id_ready, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, wb_rd_addr, ex_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm, alu_res32bit, wb_result;
  logic [3:0]  id_sel, sel;
  logic        wb_valid, wb_reg_write, ex_ready, flush;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] x32bit, y32bit, ex_store_data;
  int vecs = 0, errs = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_sel(id_sel), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .alu_res32bit(alu_res32bit), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_result(wb_result), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .x32bit(x32bit), .y32bit(y32bit), .sel(sel),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic ui, input logic [3:0] s, input logic rw, input logic mr,
                       input logic mw);
    id_valid = 1'b1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_use_imm = ui;
    id_sel = s; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_reg_write = v; wb_rd_addr = rd; wb_result = d;
  endtask

  initial begin
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    set_wb(0, 0, 0);
    alu_res32bit = '0; ex_ready = 1'b1; flush = 1'b0;
    #12;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_sel", 32'(sel), 32'h7);
    chk("rst_x", x32bit, 0);
    chk("rst_y", y32bit, 0);
    chk("rst_store", ex_store_data, 0);
    chk("rst_flags", {ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write}, 0);
    rst_n = 1'b1;
    // ADD r3 <- r1 + r2 into EX
    issue(1, 2, 3, 32'h5, 32'h6, 0, 0, 4'b0000, 1, 0, 0);
    tick();
    chk("add_valid", 32'(ex_valid), 1);
    chk("add_x", x32bit, 32'h5);
    chk("add_y", y32bit, 32'h6);
    chk("add_rd", 32'(ex_rd_addr), 3);
    chk("add_rw", 32'(ex_reg_write), 1);
    // SUB rs=r3 forwards the ALU result
    issue(3, 0, 5, 32'hDEAD_BEEF, 0, 0, 0, 4'b0001, 1, 0, 0);
    alu_res32bit = 32'h10;
    tick();
    chk("exfwd_x", x32bit, 32'h10);
    chk("exfwd_sel", 32'(sel), 32'h1);
    chk("exfwd_y", y32bit, 0);
    // EX holds r5; WB also writes r5: EX wins
    issue(5, 0, 0, 32'h99, 0, 0, 0, 4'b0000, 1, 0, 0);
    alu_res32bit = 32'h11;
    set_wb(1, 5, 32'h22);
    tick();
    chk("prio_x", x32bit, 32'h11);
    // EX and WB both target r0: never forwarded
    issue(0, 0, 7, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    set_wb(1, 0, 32'h22);
    tick();
    chk("r0_x", x32bit, 0);
    // WB-only forward on rs and store data, immediate on y
    issue(5, 5, 8, 32'h99, 32'h55, 32'h1234, 1, 4'b0000, 0, 0, 0);
    set_wb(1, 5, 32'h22);
    tick();
    chk("wbfwd_x", x32bit, 32'h22);
    chk("imm_y", y32bit, 32'h1234);
    chk("wbfwd_store", ex_store_data, 32'h22);
    // load r4 into EX
    issue(0, 0, 4, 0, 0, 32'h8, 1, 4'b0000, 1, 1, 0);
    set_wb(0, 0, 0);
    tick();
    chk("lw_mr", 32'(ex_mem_read), 1);
    // rt match with immediate y is not a hazard
    issue(1, 4, 9, 32'h1, 32'hBAD, 0, 1, 4'b0100, 1, 0, 0);
    #1;
    chk("lu_imm_ready", 32'(id_ready), 1);
    issue(1, 4, 9, 32'h1, 32'hBAD, 0, 0, 4'b0100, 1, 0, 0);
    #1;
    chk("lu_ready", 32'(id_ready), 0);
    tick();
    chk("lu_bub_valid", 32'(ex_valid), 0);
    chk("lu_bub_sel", 32'(sel), 32'h7);
    chk("lu_bub_mr", 32'(ex_mem_read), 0);
    set_wb(1, 4, 32'h0F0F_0000);
    #1;
    chk("lu_ready2", 32'(id_ready), 1);
    tick();
    chk("lu_y", y32bit, 32'h0F0F_0000);
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_sel", 32'(sel), 32'h4);
    chk("lu_store", ex_store_data, 32'h0F0F_0000);
    // downstream stall for 3 cycles
    set_wb(0, 0, 0);
    issue(2, 0, 10, 32'h77, 0, 0, 0, 4'b0101, 1, 0, 0);
    ex_ready = 1'b0;
    #1;
    chk("stall_ready", 32'(id_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(ex_valid), 1);
      chk("stall_sel", 32'(sel), 32'h4);
      chk("stall_x", x32bit, 32'h1);
      chk("stall_y", y32bit, 32'h0F0F_0000);
      chk("stall_rd", 32'(ex_rd_addr), 9);
      chk("stall_rdy", 32'(id_ready), 0);
    end
    ex_ready = 1'b1;
    #1;
    chk("rel_ready", 32'(id_ready), 1);
    tick();
    chk("rel_x", x32bit, 32'h77);
    chk("rel_sel", 32'(sel), 32'h5);
    // flush during stall
    ex_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(id_ready), 1);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_sel", 32'(sel), 32'h7);
    chk("flush_rw", 32'(ex_reg_write), 0);
    flush = 1'b0;
    ex_ready = 1'b1;
    // asynchronous reset mid-operation
    issue(1, 2, 6, 32'hAA, 32'hBB, 0, 0, 4'b1010, 1, 0, 0);
    tick();
    chk("pre_rst_valid", 32'(ex_valid), 1);
    chk("pre_rst_x", x32bit, 32'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 0);
    chk("arst_sel", 32'(sel), 32'h7);
    chk("arst_x", x32bit, 0);
    chk("arst_y", y32bit, 0);
    chk("arst_rw", 32'(ex_reg_write), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
